// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the camera frame capture controller: default geometry,
// internal FSM encoding and the 2-bit externally visible state code.
package capture_ctrl_pkg;

    localparam int DEF_H_PIXELS = 320;
    localparam int DEF_V_LINES  = 240;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 17;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_ARM,
        FSM_SYNC,
        FSM_CAPTURE,
        FSM_DONE,
        FSM_ERROR
    } fsm_state_e;

    typedef enum logic [1:0] {
        EXT_IDLE        = 2'd0,
        EXT_CAPTURING   = 2'd1,
        EXT_FRAME_VALID = 2'd2,
        EXT_ERROR       = 2'd3
    } ext_state_e;

    // ARM and SYNC are reported as idle; busy distinguishes them from IDLE.
    function automatic ext_state_e ext_state(input fsm_state_e s);
        case (s)
            FSM_CAPTURE: return EXT_CAPTURING;
            FSM_DONE:    return EXT_FRAME_VALID;
            FSM_ERROR:   return EXT_ERROR;
            default:     return EXT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/line_counter.sv
// Column/row counting for one frame: href falling-edge detection, line length
// check and the per-pixel accept decision used by the capture FSM.
module line_counter #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int CW       = $clog2(H_PIXELS + 1),
    parameter int RW       = $clog2(V_LINES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic hold_i,
    input  logic href_i,
    input  logic pix_valid_i,
    output logic accept_o,
    output logic overflow_o,
    output logic line_short_o,
    output logic frame_end_o
);

    localparam logic [CW-1:0] COL_FULL = CW'(H_PIXELS);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_LINES - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          href_q;
    logic          pix;
    logic          line_end;
    logic          col_full;

    assign col_full     = (col_q == COL_FULL);
    assign pix          = ~clear_i & href_i & pix_valid_i;
    assign accept_o     = pix & ~hold_i & ~col_full;
    assign overflow_o   = pix & col_full;
    assign line_end     = ~clear_i & href_q & ~href_i;
    assign line_short_o = line_end & ~col_full;
    assign frame_end_o  = line_end & col_full & (row_q == ROW_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (accept_o) begin
            col_d = col_q + CW'(1);
        end else if (line_end && col_full) begin
            col_d = '0;
            row_d = row_q + RW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q  <= '0;
            row_q  <= '0;
            href_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            href_q <= href_i;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Captures one camera frame into a frame buffer: arms on start, aligns to the
// vsync falling edge, writes pixels in raster order and flags framing errors.
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_LINES  = DEF_V_LINES,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        state,
    output logic              busy,
    output logic              done,
    output logic              err
);

    fsm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic accept;
    logic overflow;
    logic line_short;
    logic frame_end;
    logic counting;
    logic start_ok;

    assign counting = (state_q == FSM_CAPTURE);

    line_counter #(
        .H_PIXELS(H_PIXELS),
        .V_LINES (V_LINES)
    ) u_line_counter (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (~counting),
        .hold_i      (abort | vsync),
        .href_i      (href),
        .pix_valid_i (pix_valid),
        .accept_o    (accept),
        .overflow_o  (overflow),
        .line_short_o(line_short),
        .frame_end_o (frame_end)
    );

    // start is only honoured while not busy, and a simultaneous abort vetoes it.
    assign start_ok = start & ~abort &
                      ((state_q == FSM_IDLE) || (state_q == FSM_DONE) || (state_q == FSM_ERROR));

    always_comb begin
        state_d = state_q;
        case (state_q)
            FSM_IDLE:    if (start_ok) state_d = FSM_ARM;
            FSM_ARM: begin
                if (abort)      state_d = FSM_IDLE;
                else if (vsync) state_d = FSM_SYNC;
            end
            FSM_SYNC: begin
                if (abort)       state_d = FSM_IDLE;
                else if (!vsync) state_d = FSM_CAPTURE;
            end
            FSM_CAPTURE: begin
                if (abort)                                state_d = FSM_IDLE;
                else if (vsync || overflow || line_short) state_d = FSM_ERROR;
                else if (frame_end)                       state_d = FSM_DONE;
            end
            FSM_DONE:    if (start_ok) state_d = FSM_ARM;
            FSM_ERROR:   if (start_ok) state_d = FSM_ARM;
            default:     state_d = FSM_IDLE;
        endcase
    end

    // Write port: wr_en is a one-cycle strobe with no back-pressure; wr_addr and
    // wr_data are valid in the same cycle and hold their last value otherwise.
    always_comb begin
        addr_d    = addr_q;
        wr_en_d   = accept;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (!counting) begin
            addr_d = '0;
        end else if (accept) begin
            addr_d    = addr_q + ADDR_W'(1);
            wr_addr_d = addr_q;
            wr_data_d = pix_data;
        end
    end

    always_comb begin
        done_d = counting && (state_d == FSM_DONE);
        err_d  = err_q;
        if (start_ok)                     err_d = 1'b0;
        else if (state_d == FSM_ERROR)    err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FSM_IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign err     = err_q;
    assign state   = ext_state(state_q);
    assign busy    = (state_q == FSM_ARM) || (state_q == FSM_SYNC) || (state_q == FSM_CAPTURE);

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl on a reduced 16x12 frame: nominal frames,
// framing errors, abort, mid-frame start and reset during capture.
module tb_capture_ctrl;

    localparam int H  = 16;
    localparam int V  = 12;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int W  = AW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          vsync;
    logic          href;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    state;
    logic          busy;
    logic          done;
    logic          err;

    int checks    = 0;
    int failures  = 0;
    int wr_cnt    = 0;
    int done_cnt  = 0;
    int frame_id  = 0;
    int exp_addr  = 0;
    int w0        = 0;
    int d0        = 0;
    logic [AW-1:0] last_addr = '0;
    logic [W-1:0]  exp_q[$];

    always #5 clk = ~clk;

    capture_ctrl #(
        .H_PIXELS(H),
        .V_LINES (V),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .vsync    (vsync),
        .href     (href),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .state    (state),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int f, input int r, input int c);
        return DW'(f * 37 + r * 16 + c * 5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_frame();
        frame_id++;
        exp_addr = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_vsync();
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_line(input int r, input int n, input bit exp_wr);
        href = 1'b1;
        for (int c = 0; c < n; c++) begin
            pix_valid = 1'b1;
            pix_data  = pat(frame_id, r, c);
            if (exp_wr) begin
                exp_q.push_back({AW'(exp_addr), pix_data});
                exp_addr++;
            end
            tick();
        end
        href      = 1'b0;
        pix_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_frame();
        for (int r = 0; r < V; r++) send_line(r, H, 1'b1);
    endtask

    // Write monitor / scoreboard.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 32'd1, 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[W-1:DW]));
                check("wr_data", 32'(wr_data), 32'(e[DW-1:0]));
            end
            wr_cnt++;
            last_addr = wr_addr;
        end
        if (done) done_cnt++;
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; vsync = 1'b0;
        href = 1'b0; pix_valid = 1'b0; pix_data = '0;
        tick(); tick(); tick();
        check("rst_wr_en",   32'(wr_en),   32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_state",   32'(state),   32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_err",     32'(err),     32'd0);
        rst = 1'b0;
        tick();

        // Nominal frame.
        new_frame();
        pulse_start();
        check("nom_arm_busy",  32'(busy),  32'd1);
        check("nom_arm_state", 32'(state), 32'd0);
        send_vsync();
        check("nom_cap_state", 32'(state), 32'd1);
        send_frame();
        check("nom_done_cnt",  32'(done_cnt),     32'd1);
        check("nom_state",     32'(state),        32'd2);
        check("nom_busy",      32'(busy),         32'd0);
        check("nom_wr_cnt",    32'(wr_cnt),       32'(H * V));
        check("nom_last_addr", 32'(last_addr),    32'(H * V - 1));
        check("nom_q_empty",   32'(exp_q.size()), 32'd0);

        // Short line 5.
        new_frame();
        pulse_start();
        send_vsync();
        for (int r = 0; r < 5; r++) send_line(r, H, 1'b1);
        send_line(5, H - 1, 1'b1);
        check("short_err",   32'(err),   32'd1);
        check("short_state", 32'(state), 32'd3);
        check("short_busy",  32'(busy),  32'd0);
        w0 = wr_cnt;
        send_line(6, H, 1'b0);
        check("short_no_wr", 32'(wr_cnt), 32'(w0));

        // Early vsync after 6 lines.
        new_frame();
        pulse_start();
        check("early_err_clr", 32'(err),   32'd0);
        check("early_busy",    32'(busy),  32'd1);
        send_vsync();
        for (int r = 0; r < 6; r++) send_line(r, H, 1'b1);
        vsync = 1'b1;
        tick();
        tick();
        check("early_state",     32'(state),     32'd3);
        check("early_err",       32'(err),       32'd1);
        check("early_last_addr", 32'(last_addr), 32'(6 * H - 1));
        vsync = 1'b0;
        tick();

        // Abort at row 3, col 5, then a clean frame.
        new_frame();
        pulse_start();
        send_vsync();
        for (int r = 0; r < 3; r++) send_line(r, H, 1'b1);
        d0   = done_cnt;
        href = 1'b1;
        for (int c = 0; c < 5; c++) begin
            pix_valid = 1'b1;
            pix_data  = pat(frame_id, 3, c);
            exp_q.push_back({AW'(exp_addr), pix_data});
            exp_addr++;
            tick();
        end
        abort    = 1'b1;
        pix_data = pat(frame_id, 3, 5);
        tick();
        abort = 1'b0; href = 1'b0; pix_valid = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_err",   32'(err),   32'd0);
        tick(); tick(); tick();
        check("abort_no_done", 32'(done_cnt),     32'(d0));
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        new_frame();
        pulse_start();
        send_vsync();
        send_frame();
        check("restart_done",  32'(done_cnt),  32'(d0 + 1));
        check("restart_state", 32'(state),     32'd2);
        check("restart_last",  32'(last_addr), 32'(H * V - 1));

        // Start mid-frame, then a start while busy.
        new_frame();
        w0   = wr_cnt;
        href = 1'b1;
        for (int c = 0; c < H; c++) begin
            pix_valid = 1'b1;
            pix_data  = pat(frame_id, 0, c);
            start     = (c == 3);
            tick();
        end
        start = 1'b0; href = 1'b0; pix_valid = 1'b0;
        tick();
        check("mid_state", 32'(state), 32'd0);
        check("mid_busy",  32'(busy),  32'd1);
        send_line(1, H, 1'b0);
        send_line(2, H, 1'b0);
        check("mid_no_wr", 32'(wr_cnt), 32'(w0));
        pulse_start();
        check("busy_start_state", 32'(state), 32'd0);
        check("busy_start_busy",  32'(busy),  32'd1);
        d0 = done_cnt;
        send_vsync();
        send_frame();
        check("mid_done",   32'(done_cnt), 32'(d0 + 1));
        check("mid_wr_cnt", 32'(wr_cnt),   32'(w0 + H * V));

        // Reset during capture.
        new_frame();
        pulse_start();
        send_vsync();
        send_line(0, H, 1'b1);
        d0   = done_cnt;
        href = 1'b1;
        for (int c = 0; c < 4; c++) begin
            pix_valid = 1'b1;
            pix_data  = pat(frame_id, 1, c);
            exp_q.push_back({AW'(exp_addr), pix_data});
            exp_addr++;
            tick();
        end
        rst      = 1'b1;
        pix_data = pat(frame_id, 1, 4);
        tick();
        check("midrst_wr_en",   32'(wr_en),   32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_state",   32'(state),   32'd0);
        check("midrst_busy",    32'(busy),    32'd0);
        check("midrst_done",    32'(done),    32'd0);
        check("midrst_err",     32'(err),     32'd0);
        rst = 1'b0; href = 1'b0; pix_valid = 1'b0;
        tick(); tick();
        check("midrst_no_done", 32'(done_cnt),     32'(d0));
        check("final_q_empty",  32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
